// File: rtl/pio_ext.sv
// WIDTH-channel bidirectional GPIO on Avalon-MM: direction control, atomic set/clear,
// two-flop input synchronisation, per-bit edge capture and a maskable level interrupt.
module pio_ext #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter int               EDGE_TYPE = 0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [1:0]       warm_q, warm_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] ec_clr;
    logic [31:0]      rd_word;
    logic [31:0]      writedata_unused;

    assign wd               = avs_writedata[WIDTH-1:0];
    assign writedata_unused = avs_writedata;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_raw = sync2_q & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_raw = ~sync2_q & prev_q;
        end else begin : g_both
            assign edge_raw = sync2_q ^ prev_q;
        end
    endgenerate

    // Pins already high at reset release would otherwise look like a rising edge.
    assign edge_det = (warm_q == 2'd3) ? edge_raw : '0;
    assign warm_d   = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        ec_clr = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA:    out_d  = wd;
                ADDR_DIR:     dir_d  = wd;
                ADDR_IRQMASK: mask_d = wd;
                ADDR_EDGECAP: ec_clr = wd;
                ADDR_OUTSET:  out_d  = out_q | wd;
                ADDR_OUTCLR:  out_d  = out_q & ~wd;
                default:      ;
            endcase
        end
        // A fresh edge overrides a clear landing in the same cycle.
        edgecap_d = (edgecap_q & ~ec_clr) | edge_det;
    end

    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_DATA:    rd_word[WIDTH-1:0] = (dir_q & out_q) | (~dir_q & sync2_q);
            ADDR_DIR:     rd_word[WIDTH-1:0] = dir_q;
            ADDR_IRQMASK: rd_word[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rd_word[WIDTH-1:0] = edgecap_q;
            default:      rd_word = '0;
        endcase
        readdata_d = avs_read ? rd_word : readdata_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_q      <= RESET_OUT;
            dir_q      <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            warm_q     <= 2'd0;
            readdata_q <= '0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            sync1_q    <= pio_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            warm_q     <= warm_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = |(edgecap_q & mask_q);
    assign pio_out      = out_q;
    assign pio_oe       = dir_q;

endmodule

// File: tb/tb_pio_ext.sv
// Scoreboarded bench for pio_ext: expected read data is queued when a read is issued
// and compared when the registered read data appears one cycle later.
module tb_pio_ext;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [7:0]  pio_in = '0;
    logic [7:0]  pio_out;
    logic [7:0]  pio_oe;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    pio_ext #(.WIDTH(8), .RESET_OUT(8'h00), .EDGE_TYPE(0)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .pio_in        (pio_in),
        .pio_out       (pio_out),
        .pio_oe        (pio_oe)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Read data monitor: pops one expectation per read accepted while out of reset.
    always begin
        @(posedge clk_clk);
        if (avs_read === 1'b1 && reset_reset_n === 1'b1) begin
            #1;
            if (exp_q.size() == 0) begin
                check_val("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                check_val(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        avs_address = addr;
        avs_read    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick(1);
        avs_read    = 1'b0;
    endtask

    task automatic do_reset(input logic [7:0] pins);
        pio_in        = pins;
        reset_reset_n = 1'b0;
        tick(3);
        reset_reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and empty register map
        do_reset(8'h00);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        check_val("rst_oe", {24'd0, pio_oe}, 32'd0);
        check_val("rst_out", {24'd0, pio_out}, 32'd0);
        check_val("rst_readdata", avs_readdata, 32'd0);
        for (int a = 0; a < 8; a++) bus_read(3'(a), 32'd0, $sformatf("rst_rd%0d", a));

        // Output path: DATA, OUTSET, OUTCLR
        bus_write(3'd1, 32'h0000_00FF);
        check_val("oe_ff", {24'd0, pio_oe}, 32'hFF);
        bus_write(3'd0, 32'h0000_00A5);
        check_val("out_a5", {24'd0, pio_out}, 32'hA5);
        bus_write(3'd4, 32'h0000_000A);
        check_val("out_af", {24'd0, pio_out}, 32'hAF);
        bus_write(3'd5, 32'h0000_0081);
        check_val("out_2e", {24'd0, pio_out}, 32'h2E);
        bus_read(3'd0, 32'h2E, "data_2e");
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_read(3'd0, 32'h0000_00FF, "data_upper_zero");
        bus_write(3'd0, 32'h0000_002E);
        bus_write(3'd6, 32'hFFFF_FFFF);
        check_val("unmapped_write_ignored", {24'd0, pio_out}, 32'h2E);
        bus_read(3'd4, 32'd0, "outset_reads0");
        bus_read(3'd6, 32'd0, "unmapped_reads0");

        // Read and write to the same offset in one cycle returns the old value
        avs_address = 3'd1; avs_writedata = 32'h0F; avs_write = 1'b1; avs_read = 1'b1;
        exp_q.push_back(32'hFF); tag_q.push_back("rw_same_old");
        tick(1);
        avs_write = 1'b0; avs_read = 1'b0;
        bus_read(3'd1, 32'h0F, "dir_new");
        bus_write(3'd1, 32'h00);

        // Rising edge capture latency and W1C
        bus_write(3'd2, 32'h01);
        bus_read(3'd2, 32'h01, "irqmask");
        pio_in[0] = 1'b1;
        tick(2);
        check_val("irq_before_k2", {31'd0, irq}, 32'd0);
        tick(1);
        check_val("irq_at_k2", {31'd0, irq}, 32'd1);
        bus_read(3'd3, 32'h01, "edgecap_set");
        bus_read(3'd0, 32'h01, "data_sync_in");
        bus_write(3'd3, 32'h01);
        check_val("irq_after_w1c", {31'd0, irq}, 32'd0);
        pio_in[0] = 1'b0;
        tick(5);
        check_val("fall_no_irq", {31'd0, irq}, 32'd0);
        bus_read(3'd3, 32'h00, "fall_no_capture");
        pio_in[1] = 1'b1;
        tick(5);
        check_val("unmasked_no_irq", {31'd0, irq}, 32'd0);
        bus_read(3'd3, 32'h02, "capture_unmasked");
        bus_write(3'd3, 32'h02);
        pio_in[1] = 1'b0;
        tick(4);

        // Edge and W1C on the same bit in the same cycle: set wins
        pio_in[0] = 1'b1;
        tick(4);
        check_val("irq_pre_collide", {31'd0, irq}, 32'd1);
        pio_in[0] = 1'b0;
        tick(4);
        pio_in[0] = 1'b1;
        tick(2);
        bus_write(3'd3, 32'h01);
        check_val("collide_irq", {31'd0, irq}, 32'd1);
        bus_read(3'd3, 32'h01, "collide_edgecap");
        bus_write(3'd3, 32'h01);
        check_val("collide_cleared", {31'd0, irq}, 32'd0);

        // Warm-up suppression with pins high through reset
        do_reset(8'hFF);
        tick(10);
        bus_read(3'd3, 32'h00, "warmup_no_capture");
        bus_read(3'd0, 32'hFF, "warmup_data_ff");
        check_val("warmup_out", {24'd0, pio_out}, 32'h00);

        // Asynchronous reset in the middle of a read
        bus_write(3'd1, 32'hFF);
        bus_write(3'd0, 32'h5A);
        bus_write(3'd2, 32'hFF);
        pio_in = 8'h00;
        tick(4);
        pio_in = 8'h01;
        tick(4);
        check_val("pre_rst_irq", {31'd0, irq}, 32'd1);
        bus_read(3'd1, 32'hFF, "pre_rst_dir");
        avs_address = 3'd2;
        avs_read    = 1'b1;
        #2;
        reset_reset_n = 1'b0;
        #1;
        avs_read = 1'b0;
        check_val("midrd_readdata", avs_readdata, 32'd0);
        check_val("midrd_out", {24'd0, pio_out}, 32'd0);
        check_val("midrd_oe", {24'd0, pio_oe}, 32'd0);
        check_val("midrd_irq", {31'd0, irq}, 32'd0);
        tick(2);
        reset_reset_n = 1'b1;
        tick(2);

        check_val("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
